// File: rtl/gfx256_pkg.sv
// Shared types and constants for the gfx256 Wishbone read path.
package gfx256_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StBus,
    StResp
  } rd_state_e;

  typedef enum logic {
    CliZ,
    CliT
  } rd_client_e;

  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned LineOffW   = $clog2(LINE_BYTES);
  localparam int unsigned LineTagW   = 32 - LineOffW;

endpackage

// File: rtl/gfx256_rd_arb.sv
// Two-way round-robin arbiter between the z and texture clients, with per-client lockout.
module gfx256_rd_arb
  import gfx256_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       z_req_i,
  input  logic       t_req_i,
  input  logic       z_lock_i,
  input  logic       t_lock_i,
  output logic       gnt_o,
  output rd_client_e gnt_cli_o
);

  rd_client_e last_q;
  logic       z_elig;
  logic       t_elig;

  always_comb begin
    z_elig = z_req_i && !z_lock_i;
    t_elig = t_req_i && !t_lock_i;
    gnt_o  = en_i && (z_elig || t_elig);
    if (z_elig && t_elig) begin
      gnt_cli_o = (last_q == CliZ) ? CliT : CliZ;
    end else if (z_elig) begin
      gnt_cli_o = CliZ;
    end else begin
      gnt_cli_o = CliT;
    end
  end

  // Resetting to the texture client makes z win the first contested grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= CliT;
    end else if (gnt_o) begin
      last_q <= gnt_cli_o;
    end
  end

endmodule

// File: rtl/gfx256_wbm_read.sv
// 256-bit Wishbone read master serving the z and texture clients, with a one-line reuse buffer.
module gfx256_wbm_read
  import gfx256_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          LINE_REUSE = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         z_request_i,
  input  logic [31:0]  z_addr_i,
  input  logic [31:0]  z_sel_i,
  output logic         z_ack_o,
  output logic [255:0] z_data_o,
  input  logic         t_request_i,
  input  logic [31:0]  t_addr_i,
  input  logic [31:0]  t_sel_i,
  output logic         t_ack_o,
  output logic [255:0] t_data_o,
  output logic         busy_o,
  output logic         err_o,
  output logic         m_cyc_o,
  output logic         m_stb_o,
  output logic         m_we_o,
  output logic [31:0]  m_sel_o,
  output logic [31:0]  m_adr_o,
  input  logic [255:0] m_dat_i,
  input  logic         m_ack_i,
  input  logic         m_err_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  rd_state_e            state_q, state_d;
  rd_client_e           cur_cli_q, gnt_cli;
  logic                 gnt;
  logic [LineTagW-1:0]  cur_line_q;
  logic [31:0]          cur_sel_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [LineTagW-1:0]  tag_q, tag_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [255:0]         buf_data_q, buf_data_d;
  logic                 flushed_q, flushed_d;
  logic                 err_q, err_d;
  logic [255:0]         z_data_q, z_data_d;
  logic [255:0]         t_data_q, t_data_d;
  logic                 z_lock_q, t_lock_q;
  logic                 hit;
  logic                 timeout;
  logic                 resp_load;
  logic [255:0]         resp_data;
  logic                 in_bus;
  logic                 unused_offset;

  // Only the line address matters; byte offsets within the line are dropped.
  assign unused_offset = ^{z_addr_i[LineOffW-1:0], t_addr_i[LineOffW-1:0]};

  gfx256_rd_arb u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (state_q == StIdle),
    .z_req_i   (z_request_i),
    .t_req_i   (t_request_i),
    .z_lock_i  (z_lock_q),
    .t_lock_i  (t_lock_q),
    .gnt_o     (gnt),
    .gnt_cli_o (gnt_cli)
  );

  assign hit     = LINE_REUSE && buf_valid_q && (cur_line_q == tag_q) && !flush_i;
  assign timeout = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    flushed_d   = flushed_q;
    err_d       = err_q;
    resp_load   = 1'b0;
    resp_data   = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt) begin
          state_d   = StCheck;
          flushed_d = 1'b0;
        end
      end
      StCheck: begin
        if (hit) begin
          state_d   = StResp;
          resp_load = 1'b1;
          resp_data = buf_data_q;
        end else begin
          state_d = StBus;
          cnt_d   = '0;
        end
      end
      StBus: begin
        if (m_ack_i) begin
          state_d   = StResp;
          resp_load = 1'b1;
          resp_data = m_dat_i;
          if (LINE_REUSE) begin
            tag_d       = cur_line_q;
            buf_data_d  = m_dat_i;
            buf_valid_d = !flushed_q;
          end
        end else if (m_err_i || timeout) begin
          state_d     = StResp;
          resp_load   = 1'b1;
          err_d       = 1'b1;
          buf_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A flush seen while a read is outstanding must keep that read's line out of the buffer.
    if (flush_i) begin
      buf_valid_d = 1'b0;
      if (state_q == StCheck || state_q == StBus) begin
        flushed_d = 1'b1;
      end
    end
  end

  always_comb begin
    z_data_d = z_data_q;
    t_data_d = t_data_q;
    if (resp_load) begin
      if (cur_cli_q == CliZ) begin
        z_data_d = resp_data;
      end else begin
        t_data_d = resp_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cur_cli_q   <= CliZ;
      cur_line_q  <= '0;
      cur_sel_q   <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      flushed_q   <= 1'b0;
      err_q       <= 1'b0;
      z_data_q    <= '0;
      t_data_q    <= '0;
      z_lock_q    <= 1'b0;
      t_lock_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      flushed_q   <= flushed_d;
      err_q       <= err_d;
      z_data_q    <= z_data_d;
      t_data_q    <= t_data_d;
      z_lock_q    <= z_ack_o;
      t_lock_q    <= t_ack_o;
      if (gnt) begin
        cur_cli_q  <= gnt_cli;
        cur_line_q <= (gnt_cli == CliZ) ? z_addr_i[31:LineOffW] : t_addr_i[31:LineOffW];
        cur_sel_q  <= (gnt_cli == CliZ) ? z_sel_i : t_sel_i;
      end
    end
  end

  assign in_bus   = (state_q == StBus);
  assign m_cyc_o  = in_bus;
  assign m_stb_o  = in_bus;
  assign m_we_o   = 1'b0;
  assign m_adr_o  = in_bus ? {cur_line_q, {LineOffW{1'b0}}} : '0;
  assign m_sel_o  = in_bus ? cur_sel_q : '0;
  assign z_ack_o  = (state_q == StResp) && (cur_cli_q == CliZ);
  assign t_ack_o  = (state_q == StResp) && (cur_cli_q == CliT);
  assign z_data_o = z_data_q;
  assign t_data_o = t_data_q;
  assign busy_o   = (state_q != StIdle);
  assign err_o    = err_q;

endmodule

// File: tb/tb_gfx256_wbm_read.sv
// Scoreboard bench for gfx256_wbm_read: directed client reads against a behavioural Wishbone slave.
module tb_gfx256_wbm_read;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  logic         z_request_i;
  logic [31:0]  z_addr_i;
  logic [31:0]  z_sel_i;
  logic         z_ack_o;
  logic [255:0] z_data_o;
  logic         t_request_i;
  logic [31:0]  t_addr_i;
  logic [31:0]  t_sel_i;
  logic         t_ack_o;
  logic [255:0] t_data_o;
  logic         busy_o;
  logic         err_o;
  logic         m_cyc_o;
  logic         m_stb_o;
  logic         m_we_o;
  logic [31:0]  m_sel_o;
  logic [31:0]  m_adr_o;
  logic [255:0] m_dat_i;
  logic         m_ack_i;
  logic         m_err_i;

  gfx256_wbm_read #(
    .TIMEOUT    (8),
    .LINE_REUSE (1'b1)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .z_request_i (z_request_i),
    .z_addr_i    (z_addr_i),
    .z_sel_i     (z_sel_i),
    .z_ack_o     (z_ack_o),
    .z_data_o    (z_data_o),
    .t_request_i (t_request_i),
    .t_addr_i    (t_addr_i),
    .t_sel_i     (t_sel_i),
    .t_ack_o     (t_ack_o),
    .t_data_o    (t_data_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .m_cyc_o     (m_cyc_o),
    .m_stb_o     (m_stb_o),
    .m_we_o      (m_we_o),
    .m_sel_o     (m_sel_o),
    .m_adr_o     (m_adr_o),
    .m_dat_i     (m_dat_i),
    .m_ack_i     (m_ack_i),
    .m_err_i     (m_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           is_t;
    logic [255:0] data;
  } resp_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] sel;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    vectors      = 0;
  int    miscompares  = 0;
  int    bus_count    = 0;
  int    last_cyc_len = 0;
  int    cur_len      = 0;
  bit    prev_cyc     = 1'b0;
  bit    slave_mute   = 1'b0;
  int    slave_delay  = 3;
  bit    stray_ack    = 1'b0;

  function automatic logic [255:0] line_data(input logic [31:0] a);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(i + 1));
    return d;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Client model: holds its request until ack, then for one more cycle (registered drop).
  task automatic client_read(input bit is_t, input logic [31:0] a, input logic [31:0] s,
                             output int lat);
    if (is_t) begin
      t_request_i = 1'b1; t_addr_i = a; t_sel_i = s;
    end else begin
      z_request_i = 1'b1; z_addr_i = a; z_sel_i = s;
    end
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (is_t ? t_ack_o : z_ack_o) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_wait_%s: got no ack expected ack within 100 cycles", is_t ? "t" : "z");
    end
    tick();
    tick();
    if (is_t) t_request_i = 1'b0;
    else      z_request_i = 1'b0;
  endtask

  task automatic expect_read(input bit is_t, input logic [31:0] a, input logic [31:0] s,
                             input bit on_bus, input logic [255:0] data);
    resp_t r;
    bus_t  b;
    r.is_t = is_t;
    r.data = data;
    resp_q.push_back(r);
    if (on_bus) begin
      b.adr = {a[31:5], 5'b0};
      b.sel = s;
      bus_q.push_back(b);
    end
  endtask

  // Behavioural slave: acks on the slave_delay-th bus cycle with a line derived from the address.
  initial begin
    int scnt;
    scnt    = 0;
    m_ack_i = 1'b0;
    m_err_i = 1'b0;
    m_dat_i = '0;
    forever begin
      tick();
      if (m_cyc_o && m_stb_o) begin
        scnt++;
        if (!slave_mute && scnt == slave_delay) begin
          m_ack_i = 1'b1;
          m_dat_i = line_data(m_adr_o);
        end else begin
          m_ack_i = 1'b0;
        end
      end else begin
        scnt    = 0;
        m_ack_i = stray_ack;
        m_dat_i = stray_ack ? {8{32'hDEAD_BEEF}} : '0;
      end
    end
  end

  // Monitor: pops the scoreboard on every client ack and every bus-cycle start.
  initial begin
    resp_t r;
    bus_t  b;
    forever begin
      @(negedge clk_i);
      if (z_ack_o || t_ack_o) begin
        check("ack_onehot", 256'(z_ack_o & t_ack_o), 256'(0));
        if (resp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got z=%0b t=%0b expected no ack", z_ack_o, t_ack_o);
        end else begin
          r = resp_q.pop_front();
          check("ack_client", 256'(t_ack_o), 256'(r.is_t));
          check("ack_data", t_ack_o ? t_data_o : z_data_o, r.data);
        end
      end
      if (m_cyc_o && !prev_cyc) begin
        bus_count++;
        if (bus_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_bus: got cycle at adr %0h expected no bus cycle", m_adr_o);
        end else begin
          b = bus_q.pop_front();
          check("m_adr", 256'(m_adr_o), 256'(b.adr));
          check("m_sel", 256'(m_sel_o), 256'(b.sel));
          check("m_stb", 256'(m_stb_o), 256'(1));
          check("m_we", 256'(m_we_o), 256'(0));
        end
      end
      if (m_cyc_o) begin
        cur_len++;
      end else if (prev_cyc) begin
        last_cyc_len = cur_len;
        cur_len      = 0;
      end
      prev_cyc = m_cyc_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    int lat, lat_z, lat_t, bc0;
    rst_ni      = 1'b1;
    flush_i     = 1'b0;
    z_request_i = 1'b0;
    z_addr_i    = '0;
    z_sel_i     = '0;
    t_request_i = 1'b0;
    t_addr_i    = '0;
    t_sel_i     = '0;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_z_ack", 256'(z_ack_o), 256'(0));
    check("rst_t_ack", 256'(t_ack_o), 256'(0));
    check("rst_busy", 256'(busy_o), 256'(0));
    check("rst_err", 256'(err_o), 256'(0));
    check("rst_cyc", 256'(m_cyc_o), 256'(0));
    check("rst_stb", 256'(m_stb_o), 256'(0));
    check("rst_sel", 256'(m_sel_o), 256'(0));
    check("rst_adr", 256'(m_adr_o), 256'(0));
    check("rst_z_data", z_data_o, 256'(0));
    check("rst_t_data", t_data_o, 256'(0));
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Stray ack while idle must be ignored (any ack would hit an empty scoreboard).
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tick();
    tick();
    check("stray_busy", 256'(busy_o), 256'(0));

    // Single z read, slave acks on the third bus cycle.
    bc0 = bus_count;
    expect_read(1'b0, 32'h1000_0024, 32'hFFFF_FFFF, 1'b1, line_data(32'h1000_0020));
    client_read(1'b0, 32'h1000_0024, 32'hFFFF_FFFF, lat);
    check("single_lat", 256'(lat), 256'(5));
    check("single_cyc_len", 256'(last_cyc_len), 256'(3));
    check("single_bus_count", 256'(bus_count - bc0), 256'(1));

    // Reset in the middle of a bus cycle: cyc/stb drop at once, no ack follows.
    slave_mute = 1'b1;
    expect_read(1'b0, 32'h6000_0004, 32'h0000_000F, 1'b1, '0);
    void'(resp_q.pop_back());
    z_request_i = 1'b1;
    z_addr_i    = 32'h6000_0004;
    z_sel_i     = 32'h0000_000F;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (m_cyc_o) break;
    end
    #2 rst_ni = 1'b0;
    #1;
    check("rstbus_cyc", 256'(m_cyc_o), 256'(0));
    check("rstbus_stb", 256'(m_stb_o), 256'(0));
    check("rstbus_busy", 256'(busy_o), 256'(0));
    z_request_i = 1'b0;
    tick();
    tick();
    rst_ni     = 1'b1;
    slave_mute = 1'b0;
    tick();

    // Simultaneous z and t after reset: z first, then t, two bus cycles.
    bc0 = bus_count;
    expect_read(1'b0, 32'h2000_0040, 32'hFFFF_0000, 1'b1, line_data(32'h2000_0040));
    expect_read(1'b1, 32'h3000_0000, 32'h0000_FFFF, 1'b1, line_data(32'h3000_0000));
    fork
      client_read(1'b0, 32'h2000_0040, 32'hFFFF_0000, lat_z);
      client_read(1'b1, 32'h3000_0000, 32'h0000_FFFF, lat_t);
    join
    check("rr_lat_z", 256'(lat_z), 256'(5));
    check("rr_lat_t", 256'(lat_t), 256'(11));
    check("rr_bus_count", 256'(bus_count - bc0), 256'(2));

    // Fetch a line, then a repeat read of the same line is served from the buffer.
    bc0 = bus_count;
    expect_read(1'b0, 32'h1000_0020, 32'hFFFF_FFFF, 1'b1, line_data(32'h1000_0020));
    client_read(1'b0, 32'h1000_0020, 32'hFFFF_FFFF, lat);
    expect_read(1'b0, 32'h1000_0030, 32'hFFFF_FFFF, 1'b0, line_data(32'h1000_0020));
    client_read(1'b0, 32'h1000_0030, 32'hFFFF_FFFF, lat);
    check("hit_lat", 256'(lat), 256'(2));
    check("hit_bus_count", 256'(bus_count - bc0), 256'(1));

    // A flush between the reads forces the repeat read back onto the bus.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    bc0 = bus_count;
    expect_read(1'b0, 32'h1000_0030, 32'hFFFF_FFFF, 1'b1, line_data(32'h1000_0020));
    client_read(1'b0, 32'h1000_0030, 32'hFFFF_FFFF, lat);
    check("flush_lat", 256'(lat), 256'(5));
    check("flush_bus_count", 256'(bus_count - bc0), 256'(1));

    // Flush during the bus cycle: data still returned, but the line is not kept.
    slave_delay = 4;
    bc0 = bus_count;
    expect_read(1'b0, 32'h4000_0000, 32'h1234_5678, 1'b1, line_data(32'h4000_0000));
    fork
      client_read(1'b0, 32'h4000_0000, 32'h1234_5678, lat);
      begin
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
      end
    join
    check("midflush_lat", 256'(lat), 256'(6));
    expect_read(1'b0, 32'h4000_0000, 32'h1234_5678, 1'b1, line_data(32'h4000_0000));
    client_read(1'b0, 32'h4000_0000, 32'h1234_5678, lat);
    check("midflush_bus_count", 256'(bus_count - bc0), 256'(2));
    slave_delay = 3;
    check("pre_timeout_err", 256'(err_o), 256'(0));

    // Silent slave: abort after 8 bus cycles with zero data and a sticky error.
    slave_mute = 1'b1;
    expect_read(1'b0, 32'h5000_0000, 32'hF0F0_F0F0, 1'b1, '0);
    client_read(1'b0, 32'h5000_0000, 32'hF0F0_F0F0, lat);
    check("timeout_lat", 256'(lat), 256'(10));
    check("timeout_cyc_len", 256'(last_cyc_len), 256'(8));
    check("timeout_err", 256'(err_o), 256'(1));
    slave_mute = 1'b0;

    bc0 = bus_count;
    expect_read(1'b0, 32'h5000_0000, 32'hF0F0_F0F0, 1'b1, line_data(32'h5000_0000));
    client_read(1'b0, 32'h5000_0000, 32'hF0F0_F0F0, lat);
    check("after_timeout_bus", 256'(bus_count - bc0), 256'(1));
    check("err_sticky", 256'(err_o), 256'(1));

    repeat (4) tick();
    check("z_data_hold", z_data_o, line_data(32'h5000_0000));
    check("t_data_hold", t_data_o, line_data(32'h3000_0000));
    check("resp_q_empty", 256'(resp_q.size()), 256'(0));
    check("bus_q_empty", 256'(bus_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
